// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one memory port between i-refill, d-refill and d-write-back
// Define RISCV_MEM_ARB_RR_EN for round-robin arbitration instead of fixed priority with starvation forcing.
module riscv_mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_riscv_arb_clk,
    input  logic                i_riscv_arb_rst,
    input  logic [ADDR_W-1:0]   i_icache_raddr,
    input  logic                i_icache_req,
    output logic                o_icache_done,
    output logic [DATA_W-1:0]   o_icache_rdata,
    input  logic [ADDR_W-1:0]   i_dcache_raddr,
    input  logic                i_dcache_rreq,
    output logic                o_dcache_rdone,
    output logic [DATA_W-1:0]   o_dcache_rdata,
    input  logic [ADDR_W-1:0]   i_dcache_waddr,
    input  logic [DATA_W-1:0]   i_dcache_wdata,
    input  logic [DATA_W/8-1:0] i_dcache_wstrb,
    input  logic                i_dcache_wreq,
    output logic                o_dcache_wdone,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_done,
    input  logic [DATA_W-1:0]   i_mem_rdata
);
    typedef enum logic [2:0] {IDLE, BUSY_DW, BUSY_DR, BUSY_IR, RESP} state_t;
    typedef enum logic [1:0] {SRC_DW = 2'd0, SRC_DR = 2'd1, SRC_IR = 2'd2, SRC_NONE = 2'd3} src_t;

    state_t state;
    src_t   win;

`ifdef RISCV_MEM_ARB_RR_EN
    src_t       last_grant;
    logic [2:0] req_vec;

    // Bit positions follow the src_t encoding so the search order is cyclic DW, DR, IR.
    assign req_vec = {i_icache_req, i_dcache_rreq, i_dcache_wreq};

    always_comb begin
        win = SRC_NONE;
        case (last_grant)
            SRC_DW:  win = req_vec[1] ? SRC_DR : req_vec[2] ? SRC_IR : req_vec[0] ? SRC_DW : SRC_NONE;
            SRC_DR:  win = req_vec[2] ? SRC_IR : req_vec[0] ? SRC_DW : req_vec[1] ? SRC_DR : SRC_NONE;
            default: win = req_vec[0] ? SRC_DW : req_vec[1] ? SRC_DR : req_vec[2] ? SRC_IR : SRC_NONE;
        endcase
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       force_ir;

    assign force_ir = (starve_cnt == STARVE_MAX) && i_icache_req;

    always_comb begin
        win = SRC_NONE;
        if (force_ir)
            win = SRC_IR;
        else if (i_dcache_wreq)
            win = SRC_DW;
        else if (i_dcache_rreq)
            win = SRC_DR;
        else if (i_icache_req)
            win = SRC_IR;
    end
`endif

    always_ff @(posedge i_riscv_arb_clk) begin
        if (i_riscv_arb_rst) begin
            state          <= IDLE;
            o_icache_done  <= 1'b0;
            o_icache_rdata <= '0;
            o_dcache_rdone <= 1'b0;
            o_dcache_rdata <= '0;
            o_dcache_wdone <= 1'b0;
            o_mem_req      <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
            o_mem_wstrb    <= '0;
`ifdef RISCV_MEM_ARB_RR_EN
            last_grant     <= SRC_IR;
`else
            starve_cnt     <= '0;
`endif
        end else begin
            o_icache_done  <= 1'b0;
            o_dcache_rdone <= 1'b0;
            o_dcache_wdone <= 1'b0;
            case (state)
                IDLE: begin
                    if (win != SRC_NONE) begin
                        o_mem_req <= 1'b1;
                        o_mem_we  <= (win == SRC_DW);
                        case (win)
                            SRC_DW: begin
                                o_mem_addr  <= i_dcache_waddr;
                                o_mem_wdata <= i_dcache_wdata;
                                o_mem_wstrb <= i_dcache_wstrb;
                                state       <= BUSY_DW;
                            end
                            SRC_DR: begin
                                o_mem_addr  <= i_dcache_raddr;
                                o_mem_wdata <= '0;
                                o_mem_wstrb <= '0;
                                state       <= BUSY_DR;
                            end
                            default: begin
                                o_mem_addr  <= i_icache_raddr;
                                o_mem_wdata <= '0;
                                o_mem_wstrb <= '0;
                                state       <= BUSY_IR;
                            end
                        endcase
`ifdef RISCV_MEM_ARB_RR_EN
                        last_grant <= win;
`else
                        if (win == SRC_IR || !i_icache_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 4'd1;
`endif
                    end
                end
                BUSY_DW, BUSY_DR, BUSY_IR: begin
                    if (i_mem_done) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        state     <= RESP;
                        case (state)
                            BUSY_IR: begin
                                o_icache_rdata <= i_mem_rdata;
                                o_icache_done  <= 1'b1;
                            end
                            BUSY_DR: begin
                                o_dcache_rdata <= i_mem_rdata;
                                o_dcache_rdone <= 1'b1;
                            end
                            default: o_dcache_wdone <= 1'b1;
                        endcase
                    end
                end
                // One dead cycle lets the finished requester drop its level request.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - table, directed and randomized checks for riscv_mem_arbiter
module tb_riscv_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] iaddr = '0, raddr = '0, waddr = '0, wdata = '0, mrdata = '0;
    logic [7:0]  wstrb = '0;
    logic        ireq = 1'b0, rreq = 1'b0, wreq = 1'b0, mdone = 1'b0;
    logic        o_icache_done, o_dcache_rdone, o_dcache_wdone, o_mem_req, o_mem_we;
    logic [63:0] o_icache_rdata, o_dcache_rdata, o_mem_addr, o_mem_wdata;
    logic [7:0]  o_mem_wstrb;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .i_riscv_arb_clk(clk),
        .i_riscv_arb_rst(rst),
        .i_icache_raddr(iaddr),
        .i_icache_req(ireq),
        .o_icache_done(o_icache_done),
        .o_icache_rdata(o_icache_rdata),
        .i_dcache_raddr(raddr),
        .i_dcache_rreq(rreq),
        .o_dcache_rdone(o_dcache_rdone),
        .o_dcache_rdata(o_dcache_rdata),
        .i_dcache_waddr(waddr),
        .i_dcache_wdata(wdata),
        .i_dcache_wstrb(wstrb),
        .i_dcache_wreq(wreq),
        .o_dcache_wdone(o_dcache_wdone),
        .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_wstrb(o_mem_wstrb),
        .i_mem_done(mdone),
        .i_mem_rdata(mrdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: phase 0 free, 1 one transaction outstanding, 2 turnaround.
    int          m_phase = 0, m_cur = 0, m_cnt = 0, m_last = 2;
    logic        e_req = 0, e_we = 0, e_idone = 0, e_rdone = 0, e_wdone = 0;
    logic [63:0] e_addr = '0, e_wdata = '0, e_irdata = '0, e_drdata = '0;
    logic [7:0]  e_wstrb = '0;

    // r[0]=write-back, r[1]=d-read, r[2]=i-read
    function automatic int pick(input logic [2:0] r);
`ifdef RISCV_MEM_ARB_RR_EN
        for (int k = 1; k <= 3; k++)
            if (r[(m_last + k) % 3]) return (m_last + k) % 3;
        return -1;
`else
        if (m_cnt == LIMIT && r[2]) return 2;
        for (int k = 0; k < 3; k++)
            if (r[k]) return k;
        return -1;
`endif
    endfunction

    task automatic model_edge();
        int w;
        e_idone = 0;
        e_rdone = 0;
        e_wdone = 0;
        if (rst) begin
            e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
            e_irdata = '0; e_drdata = '0;
            m_phase = 0; m_cnt = 0; m_last = 2;
        end else if (m_phase == 0) begin
            w = pick({ireq, rreq, wreq});
            if (w >= 0) begin
                e_req   = 1;
                e_we    = (w == 0);
                e_addr  = (w == 0) ? waddr : (w == 1) ? raddr : iaddr;
                e_wdata = (w == 0) ? wdata : 64'h0;
                e_wstrb = (w == 0) ? wstrb : 8'h0;
                if (w == 2 || !ireq) m_cnt = 0;
                else if (m_cnt < LIMIT) m_cnt++;
                m_last  = w;
                m_cur   = w;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (mdone) begin
                e_req = 0;
                e_we  = 0;
                m_phase = 2;
                if (m_cur == 2) begin e_irdata = mrdata; e_idone = 1; end
                else if (m_cur == 1) begin e_drdata = mrdata; e_rdone = 1; end
                else e_wdone = 1;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("mem_req", 64'(o_mem_req), 64'(e_req));
        check("mem_we", 64'(o_mem_we), 64'(e_we));
        check("mem_addr", o_mem_addr, e_addr);
        check("mem_wdata", o_mem_wdata, e_wdata);
        check("mem_wstrb", 64'(o_mem_wstrb), 64'(e_wstrb));
        check("icache_done", 64'(o_icache_done), 64'(e_idone));
        check("dcache_rdone", 64'(o_dcache_rdone), 64'(e_rdone));
        check("dcache_wdone", 64'(o_dcache_wdone), 64'(e_wdone));
        check("icache_rdata", o_icache_rdata, e_irdata);
        check("dcache_rdata", o_dcache_rdata, e_drdata);
    endtask

    typedef struct {
        logic [4:0]  in;    // {rst, ireq, rreq, wreq, mdone}
        logic [63:0] rd;
        logic [1:0]  rw;    // {mem_req, mem_we}
        logic [63:0] a;
        logic [7:0]  s;
        logic [2:0]  dn;    // {icache_done, dcache_rdone, dcache_wdone}
    } vec_t;

    vec_t tbl[17];
    int   grants[$];

    function automatic int addr_to_src(input logic [63:0] a);
        case (a)
            64'h2000: return 0;
            64'h3000: return 1;
            64'h1000: return 2;
            default:  return -1;
        endcase
    endfunction

    task automatic run_grants(input int n);
        logic prev;
        int   budget;
        prev = 1'b0;
        budget = 0;
        grants.delete();
        while (grants.size() < n && budget < 200) begin
            mdone  = o_mem_req;
            mrdata = {$urandom, $urandom};
            cycle();
            if (o_mem_req && !prev) grants.push_back(addr_to_src(o_mem_addr));
            prev = o_mem_req;
            budget++;
        end
        check("grant_count", 64'(grants.size()), 64'(n));
    endtask

    task automatic do_reset();
        rst = 1; ireq = 0; rreq = 0; wreq = 0; mdone = 0;
        cycle();
        rst = 0;
    endtask

    initial begin
        tbl[0]  = '{5'b10000, 64'h0,                   2'b00, 64'h0,    8'h00, 3'b000};
        tbl[1]  = '{5'b01000, 64'h0,                   2'b10, 64'h1000, 8'h00, 3'b000};
        tbl[2]  = '{5'b01000, 64'h0,                   2'b10, 64'h1000, 8'h00, 3'b000};
        tbl[3]  = '{5'b01000, 64'h0,                   2'b10, 64'h1000, 8'h00, 3'b000};
        tbl[4]  = '{5'b01000, 64'h0,                   2'b10, 64'h1000, 8'h00, 3'b000};
        tbl[5]  = '{5'b01000, 64'h0,                   2'b10, 64'h1000, 8'h00, 3'b000};
        tbl[6]  = '{5'b01001, 64'hDEADBEEF_CAFEF00D,   2'b00, 64'h1000, 8'h00, 3'b100};
        tbl[7]  = '{5'b00000, 64'h0,                   2'b00, 64'h1000, 8'h00, 3'b000};
        tbl[8]  = '{5'b00001, 64'h5555_5555_5555_5555, 2'b00, 64'h1000, 8'h00, 3'b000};
        tbl[9]  = '{5'b00110, 64'h0,                   2'b11, 64'h2000, 8'h0F, 3'b000};
        tbl[10] = '{5'b00110, 64'h0,                   2'b11, 64'h2000, 8'h0F, 3'b000};
        tbl[11] = '{5'b00111, 64'hAAAA_AAAA_AAAA_AAAA, 2'b00, 64'h2000, 8'h0F, 3'b001};
        tbl[12] = '{5'b00100, 64'h0,                   2'b00, 64'h2000, 8'h0F, 3'b000};
        tbl[13] = '{5'b00100, 64'h0,                   2'b10, 64'h2000, 8'h00, 3'b000};
        tbl[14] = '{5'b00101, 64'h12345678_9ABCDEF0,   2'b00, 64'h2000, 8'h00, 3'b010};
        tbl[15] = '{5'b00000, 64'h0,                   2'b00, 64'h2000, 8'h00, 3'b000};
        tbl[16] = '{5'b00001, 64'hFFFF_0000_FFFF_0000, 2'b00, 64'h2000, 8'h00, 3'b000};

        iaddr = 64'h1000; raddr = 64'h2000; waddr = 64'h2000;
        wdata = 64'h01234567_89ABCDEF; wstrb = 8'h0F;
        for (int i = 0; i < 17; i++) begin
            {rst, ireq, rreq, wreq, mdone} = tbl[i].in;
            mrdata = tbl[i].rd;
            cycle();
            check($sformatf("tbl%0d_req_we", i), 64'({o_mem_req, o_mem_we}), 64'(tbl[i].rw));
            check($sformatf("tbl%0d_addr", i), o_mem_addr, tbl[i].a);
            check($sformatf("tbl%0d_wstrb", i), 64'(o_mem_wstrb), 64'(tbl[i].s));
            check($sformatf("tbl%0d_dones", i),
                  64'({o_icache_done, o_dcache_rdone, o_dcache_wdone}), 64'(tbl[i].dn));
        end
        check("icache_rdata_final", o_icache_rdata, 64'hDEADBEEF_CAFEF00D);
        check("dcache_rdata_final", o_dcache_rdata, 64'h12345678_9ABCDEF0);

        raddr = 64'h3000;
`ifdef RISCV_MEM_ARB_RR_EN
        do_reset();
        ireq = 1; rreq = 1; wreq = 1;
        run_grants(6);
        for (int i = 0; i < grants.size() && i < 6; i++)
            check($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 3));
`else
        do_reset();
        ireq = 1; rreq = 1; wreq = 0;
        run_grants(10);
        for (int i = 0; i < grants.size() && i < 10; i++)
            check($sformatf("starve_grant%0d", i), 64'(grants[i]), (i % 5 == 4) ? 64'd2 : 64'd1);
`endif

        do_reset();
        rreq = 1;
        cycle();
        check("midop_granted", 64'(o_mem_req), 64'd1);
        cycle();
        cycle();
        rst = 1;
        cycle();
        check("midop_req_cleared", 64'(o_mem_req), 64'd0);
        check("midop_addr_cleared", o_mem_addr, 64'h0);
        rst = 0; rreq = 0; mdone = 1; mrdata = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("midop_late_done", 64'(o_dcache_rdone), 64'd0);
        end
        check("midop_rdata", o_dcache_rdata, 64'h0);

        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 79) == 0);
            ireq   = ($urandom_range(0, 2) != 0);
            rreq   = ($urandom_range(0, 2) == 0);
            wreq   = ($urandom_range(0, 3) == 0);
            mdone  = ($urandom_range(0, 3) == 0);
            iaddr  = {$urandom, $urandom};
            raddr  = {$urandom, $urandom};
            waddr  = {$urandom, $urandom};
            wdata  = {$urandom, $urandom};
            wstrb  = 8'($urandom);
            mrdata = {$urandom, $urandom};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
